// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses starting at 0, holding the core via busy.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LEN_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic             in_ready_q, in_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             xfer;

  assign xfer = in_valid && in_ready_q;

  // Next-state and registered-output computation; outputs follow the next state.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == LEN_W'(0) || len > LEN_W'(DEPTH_WORDS)) begin
            error_d = 1'b1;
          end else begin
            len_d      = len;
            word_idx_d = LEN_W'(0);
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
            state_d    = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte goes straight into the write data, so the write issues next cycle.
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'({word_idx_q, 2'b00});
            mem_wdata_d = {in_data, word_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        if (word_idx_q == len_q - LEN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + LEN_W'(1);
          state_d    = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_COLLECT);
    busy_d     = (state_d == S_COLLECT) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 32'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
